// File: rtl/dm_access_ctrl.sv
// Data-memory access stage: request FIFO, in-order req/ack issue, load return, terminate drain.
// Optional access statistics are enabled by defining DM_ACC_STAT_EN.
module dm_access_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        dm_dopc_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_rdy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              ld_valid_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              term_done_o,
    output logic              ovf_err_o,
    output logic [15:0]       ld_cnt_o,
    output logic [15:0]       st_cnt_o
);

    // state   | meaning
    // S_IDLE  | nothing in flight; waiting for a queued op or a pending terminate
    // S_ISSUE | head entry presented to memory with mem_req_o=1 until acked
    // S_TERM  | FIFO drained with terminate pending; pulse term_done_o once

    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_TERM  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic [FIFO_AW:0]  rd_ptr_inc;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              last;
    logic              term_pend;
    logic [ENT_W-1:0]  head;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign dm_rdy_o   = ~full & ~term_pend;
    assign push       = dm_dopc_i[2] & dm_rdy_o;
    assign rd_ptr_inc = rd_ptr + (FIFO_AW+1)'(1);
    // Popping the only entry with nothing arriving behind it leaves the FIFO empty.
    assign last       = (rd_ptr_inc == wr_ptr) && !push;

    assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign head_we    = head[ENT_W-1];
    assign head_addr  = head[ADDR_W+DATA_W-1:DATA_W];
    assign head_wdata = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {dm_dopc_i[1], dm_addr_i, dm_wdata_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            term_pend <= 1'b0;
            ovf_err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            // A new terminate wins over the clear so a request is never lost.
            if (dm_dopc_i[0]) begin
                term_pend <= 1'b1;
            end else if (state == S_TERM) begin
                term_pend <= 1'b0;
            end
            if (dm_dopc_i[2] && !dm_rdy_o) begin
                ovf_err_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        term_done_o = 1'b0;
        pop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty || push) begin
                    state_nxt = S_ISSUE;
                end else if (term_pend) begin
                    state_nxt = S_TERM;
                end
            end
            S_ISSUE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = head_we;
                mem_addr_o  = head_addr;
                mem_wdata_o = head_wdata;
                if (mem_ack_i) begin
                    pop = 1'b1;
                    // Going straight to TERM puts the drain pulse one cycle after the last ack.
                    if (last) begin
                        state_nxt = term_pend ? S_TERM : S_IDLE;
                    end
                end
            end
            S_TERM: begin
                term_done_o = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_valid_o <= 1'b0;
            ld_data_o  <= '0;
        end else begin
            ld_valid_o <= pop & ~head_we;
            if (pop && !head_we) begin
                ld_data_o <= mem_rdata_i;
            end
        end
    end

`ifdef DM_ACC_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_o <= '0;
            st_cnt_o <= '0;
        end else if (term_done_o) begin
            ld_cnt_o <= '0;
            st_cnt_o <= '0;
        end else if (pop) begin
            if (head_we) begin
                if (st_cnt_o != 16'hFFFF) begin
                    st_cnt_o <= st_cnt_o + 16'd1;
                end
            end else begin
                if (ld_cnt_o != 16'hFFFF) begin
                    ld_cnt_o <= ld_cnt_o + 16'd1;
                end
            end
        end
    end
`else
    assign ld_cnt_o = '0;
    assign st_cnt_o = '0;
`endif

endmodule
